l1_rr_arbiter: RTL and testbench
================================

# l1_rr_arbiter

Parametrised N-port arbiter between the L1 requestors (dcache, dmmu, icache, immu) and the single shared L1 memory port. It arbitrates round-robin or fixed-priority and holds the memory port per transaction, so a read burst is fully returned to its owner before the next grant. Read beats are counted and routed to the owner by port ID. It replaces hard-wired four-connection arbitration with a block scaled by the configured connection count.

## Interface
Parameters:
- NUM_PORTS, 4, requestor count (2–8); port ID width ID_W = max(1, $clog2(NUM_PORTS))
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, max beats per read (power of two); LEN_W = max(1, $clog2(MAX_BURST)); lengths encoded as beats−1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- req_rnw  in  NUM_PORTS  1 = read, 0 = write
- req_len  in  NUM_PORTS*LEN_W  read beats−1; ignored for writes
- req_wdata  in  NUM_PORTS*DATA_W  write data (single beat)
- req_ready  out  NUM_PORTS  request accepted (one-cycle pulse)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  granted address
- mem_rnw  out  1  granted direction
- mem_len  out  LEN_W  granted beats−1
- mem_wdata  out  DATA_W  granted write data
- mem_id  out  ID_W  granted port index
- mem_rd_valid  in  1  read beat valid
- mem_rd_data  in  DATA_W  read beat data
- rd_valid  out  NUM_PORTS  read beat for port i
- rd_data  out  DATA_W  shared read data (= mem_rd_data)

## Operation
- FSM states: IDLE, ISSUE, READ_WAIT.
- IDLE: if any req_valid, select the winner (see Configuration), register its addr/rnw/len/wdata/index into the mem_* outputs, go to ISSUE. If no req_valid, stay.
- ISSUE: mem_req_valid=1 with stable fields. On mem_req_valid & mem_req_ready: req_ready[grant]=1 that cycle; update rr pointer to grant; read → READ_WAIT with beat counter=0; write → IDLE.
- READ_WAIT: each mem_rd_valid raises rd_valid[grant] combinationally and increments the counter. The beat with counter==mem_len is last → IDLE.
- Requestors hold valid and fields until req_ready. A requestor dropping valid in ISSUE is illegal; the arbiter still completes the latched request.
- mem_rd_valid outside READ_WAIT is ignored: no rd_valid.
- Counter width LEN_W; mem_len=MAX_BURST−1 gives exactly MAX_BURST beats, with no wrap before the last beat.
- Ports not granted never see req_ready or rd_valid.

## Timing
- Reset values: state IDLE, mem_req_valid 0, mem_addr/mem_len/mem_wdata/mem_id/mem_rnw 0, req_ready 0, rd_valid 0, rr pointer = NUM_PORTS−1 (port 0 highest priority first).
- Request seen in IDLE at cycle t → mem_req_valid at t+1. If mem_req_ready=1 at t+1, req_ready pulses at t+1.
- Read beat at cycle u → rd_valid at u (zero latency).
- After the last read beat or a write handshake, IDLE is entered next cycle. The earliest next mem_req_valid is 2 cycles after the completing edge.
- New requests arriving during ISSUE/READ_WAIT are not considered until IDLE.
- Reset asserted mid-burst: immediate return to reset values, outstanding beats discarded, pointer reset. The memory side must also be reset.

## Configuration
- Macro L1_ARB_FIXED_PRIORITY_EN.
- Defined: the lowest-index valid port always wins; the rr pointer is unused and may be removed.
- Undefined (default): round-robin. Search starts at pointer+1 modulo NUM_PORTS; the first valid port wins. The pointer updates only on the mem handshake.

## Test plan
- Single read: port 2, addr 0x80000040, len 3, mem_req_ready=1 → mem_req_valid 1 cycle after valid with mem_id=2, req_ready[2] pulse; 4 beats 0xA0..0xA3 → rd_valid[2] ×4, then IDLE.
- Round-robin: ports 0,1,3 hold valid reads (len 0) continuously → grant order 0,1,3,0,1; each request is granted once per rotation.
- Write: port 1 write addr 0x40000000 wdata 0xDEADBEEF, mem_req_ready low 5 cycles → mem fields stable for 6 cycles, req_ready[1] only on the handshake cycle, no READ_WAIT.
- Stray beat: mem_rd_valid while IDLE → all rd_valid 0; max burst len 3 counts exactly 4 beats.
- Reset after beat 2 of 4 → all outputs at reset values the same cycle; the next request from port 3 is granted with mem_id=3.
- Fixed priority (L1_ARB_FIXED_PRIORITY_EN): ports 0 and 2 both valid and repeatedly re-requesting → port 0 granted every time.

Source files
------------

// File: rtl/l1_rr_arbiter_if.sv
// rtl/l1_rr_arbiter_if.sv - requestor and memory-port signal bundle for l1_rr_arbiter
// master = requestors plus memory model, slave = the arbiter.
interface l1_rr_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
);
  localparam int ID_W  = ($clog2(NUM_PORTS) < 1) ? 1 : $clog2(NUM_PORTS);
  localparam int LEN_W = ($clog2(MAX_BURST) < 1) ? 1 : $clog2(MAX_BURST);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]        req_rnw;
  logic [NUM_PORTS*LEN_W-1:0]  req_len;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_rnw;
  logic [LEN_W-1:0]            mem_len;
  logic [DATA_W-1:0]           mem_wdata;
  logic [ID_W-1:0]             mem_id;
  logic                        mem_rd_valid;
  logic [DATA_W-1:0]           mem_rd_data;
  logic [NUM_PORTS-1:0]        rd_valid;
  logic [DATA_W-1:0]           rd_data;

  modport master (
    output req_valid, req_addr, req_rnw, req_len, req_wdata,
    output mem_req_ready, mem_rd_valid, mem_rd_data,
    input  req_ready, mem_req_valid, mem_addr, mem_rnw, mem_len,
    input  mem_wdata, mem_id, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_addr, req_rnw, req_len, req_wdata,
    input  mem_req_ready, mem_rd_valid, mem_rd_data,
    output req_ready, mem_req_valid, mem_addr, mem_rnw, mem_len,
    output mem_wdata, mem_id, rd_valid, rd_data
  );
endinterface

// File: rtl/l1_rr_arbiter.sv
// rtl/l1_rr_arbiter.sv - N-port L1 arbiter holding the shared memory port per transaction
// L1_ARB_FIXED_PRIORITY_EN selects lowest-index-wins; default is round-robin.
module l1_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  l1_rr_arbiter_if.slave bus
);
  localparam int ID_W  = ($clog2(NUM_PORTS) < 1) ? 1 : $clog2(NUM_PORTS);
  localparam int LEN_W = ($clog2(MAX_BURST) < 1) ? 1 : $clog2(MAX_BURST);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;

  logic [1:0]           state;
  logic [LEN_W-1:0]     beat_cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic                 rnw_q;
  logic [LEN_W-1:0]     len_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [ID_W-1:0]      id_q;
  logic [NUM_PORTS-1:0] grant_oh;
  logic                 win_found;
  int                   win;

`ifndef L1_ARB_FIXED_PRIORITY_EN
  logic [ID_W-1:0]      rr_ptr;
`endif

  always_comb begin
    win       = 0;
    win_found = 1'b0;
`ifdef L1_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win       = i;
        win_found = 1'b1;
      end
    end
`else
    // Search starts one past the last granted port so it ends up lowest priority.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!win_found && bus.req_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        win       = (int'(rr_ptr) + k) % NUM_PORTS;
        win_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    grant_oh = '0;
    grant_oh[id_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      len_q    <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
`ifndef L1_ARB_FIXED_PRIORITY_EN
      rr_ptr   <= ID_W'(NUM_PORTS - 1);
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            addr_q  <= bus.req_addr[win*ADDR_W +: ADDR_W];
            rnw_q   <= bus.req_rnw[win];
            len_q   <= bus.req_len[win*LEN_W +: LEN_W];
            wdata_q <= bus.req_wdata[win*DATA_W +: DATA_W];
            id_q    <= ID_W'(win);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) begin
`ifndef L1_ARB_FIXED_PRIORITY_EN
            rr_ptr <= id_q;
`endif
            beat_cnt <= '0;
            state    <= rnw_q ? S_READ_WAIT : S_IDLE;
          end
        end
        S_READ_WAIT: begin
          if (bus.mem_rd_valid) begin
            if (beat_cnt == len_q) state <= S_IDLE;
            else                   beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = (state == S_ISSUE);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_rnw       = rnw_q;
  assign bus.mem_len       = len_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_id        = id_q;
  assign bus.req_ready     = (state == S_ISSUE && bus.mem_req_ready) ? grant_oh : '0;
  assign bus.rd_valid      = (state == S_READ_WAIT && bus.mem_rd_valid) ? grant_oh : '0;
  assign bus.rd_data       = bus.mem_rd_data;
endmodule

// File: tb/tb_l1_rr_arbiter.sv
// tb/tb_l1_rr_arbiter.sv - randomized self-checking bench for l1_rr_arbiter
// Grant order comes from a last-winner model of the arbitration rule.
module tb_l1_rr_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_rr_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) bus ();
  l1_rr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = NP - 1;

  function automatic int model_pick(input logic [NP-1:0] v);
`ifdef L1_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NP; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (v[(model_last + k) % NP]) return (model_last + k) % NP;
`endif
    return -1;
  endfunction

  task automatic idle_all;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_rnw = '0; bus.req_len = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic rnw,
                         input logic [1:0] len, input logic [DW-1:0] wd);
    bus.req_valid[p] = 1'b1;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_rnw[p] = rnw;
    bus.req_len[p*2 +: 2] = len;
    bus.req_wdata[p*DW +: DW] = wd;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = NP - 1;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; idle_all();
    bus.req_valid = '1; bus.mem_rd_valid = 1'b1; bus.mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== '0 || bus.rd_valid !== '0) begin
      n_fail++; $display("FAIL reset_handshake: got valid=%b ready=%b rd=%b, want 0", bus.mem_req_valid, bus.req_ready, bus.rd_valid);
    end
    n_tests++;
    if (bus.mem_addr !== '0 || bus.mem_len !== '0 || bus.mem_wdata !== '0 || bus.mem_id !== '0 || bus.mem_rnw !== 1'b0) begin
      n_fail++; $display("FAIL reset_fields: got addr=%h len=%0d wd=%h id=%0d rnw=%b, want 0", bus.mem_addr, bus.mem_len, bus.mem_wdata, bus.mem_id, bus.mem_rnw);
    end
    idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = NP - 1;
  endtask

  task automatic test_single_read;
    bit ok;
    @(posedge clk); #1;
    set_req(2, 32'h8000_0040, 1'b1, 2'd3, '0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL read_latency: mem_req_valid=%b in request cycle, want 0", bus.mem_req_valid); end
    @(negedge clk);
    n_tests++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_id !== 2'd2 || bus.mem_addr !== 32'h8000_0040 || bus.mem_len !== 2'd3 || bus.mem_rnw !== 1'b1) begin
      n_fail++; $display("FAIL read_issue: got v=%b id=%0d addr=%h len=%0d rnw=%b, want 1/2/80000040/3/1", bus.mem_req_valid, bus.mem_id, bus.mem_addr, bus.mem_len, bus.mem_rnw);
    end
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL read_req_ready: got %b want 0100", bus.req_ready); end
    model_last = 2;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      idle_all();
      bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 32'hA0 + b;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== 4'b0100 || bus.rd_data !== 32'hA0 + b) begin
        n_fail++; $display("FAIL read_beat%0d: got rd_valid=%b data=%h want 0100 %h", b, bus.rd_valid, bus.rd_data, 32'hA0 + b);
      end
    end
    @(posedge clk); #1;
    bus.mem_rd_data = 32'hFF;
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== '0 || bus.mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_after_last: got rd_valid=%b mem_req_valid=%b want 0 0", bus.rd_valid, bus.mem_req_valid);
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_stray_beat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b1; bus.mem_rd_data = $urandom;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== '0) begin n_fail++; $display("FAIL stray_beat: got rd_valid=%b want 0", bus.rd_valid); end
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_write;
    bit ok;
    @(posedge clk); #1;
    set_req(1, 32'h4000_0000, 1'b0, 2'd0, 32'hDEAD_BEEF);
    wait_issue(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_issue: timeout waiting for mem_req_valid"); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 5) bus.mem_req_ready = 1'b1;
        @(negedge clk);
      end
      n_tests++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h4000_0000 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_rnw !== 1'b0 || bus.mem_id !== 2'd1) begin
        n_fail++; $display("FAIL write_stable c%0d: got v=%b addr=%h wd=%h rnw=%b id=%0d", c, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_rnw, bus.mem_id);
      end
      n_tests++;
      if (bus.req_ready !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL write_req_ready c%0d: got %b want %b", c, bus.req_ready, (c == 5) ? 4'b0010 : 4'b0000);
      end
    end
    model_last = 1;
    @(posedge clk); #1;
    idle_all();
    bus.mem_rd_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== '0 || bus.mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_no_read_wait: got rd_valid=%b mem_req_valid=%b want 0 0", bus.rd_valid, bus.mem_req_valid);
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic held_requests(input logic [NP-1:0] mask, input int count);
    bit ok;
    int exp;
    logic [NP-1:0] oh;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) if (mask[p]) set_req(p, 32'h1000 * (p + 1), 1'b1, 2'd0, '0);
    bus.mem_req_ready = 1'b1;
    for (int n = 0; n < count; n++) begin
      exp = model_pick(mask);
      oh = 4'(1) << exp;
      wait_issue(ok);
      n_tests++;
      if (!ok || bus.mem_id !== 2'(exp) || bus.req_ready !== oh) begin
        n_fail++; $display("FAIL held_grant%0d: got ok=%0d id=%0d ready=%b want id=%0d ready=%b", n, ok, bus.mem_id, bus.req_ready, exp, oh);
      end
      model_last = exp;
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b1; bus.mem_rd_data = $urandom;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== oh) begin n_fail++; $display("FAIL held_beat%0d: got rd_valid=%b want %b", n, bus.rd_valid, oh); end
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b0;
    end
    idle_all();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin;
    do_reset();
    held_requests(4'b1011, 5);
  endtask

  task automatic test_priority;
    do_reset();
    held_requests(4'b0101, 4);
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    do_reset();
    @(posedge clk); #1;
    set_req(0, 32'h2000, 1'b1, 2'd3, '0);
    bus.mem_req_ready = 1'b1;
    wait_issue(ok);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      idle_all();
      bus.mem_rd_valid = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.rd_valid !== '0 || bus.mem_req_valid !== 1'b0 || bus.mem_id !== '0 || bus.mem_addr !== '0 || bus.mem_len !== '0 || bus.req_ready !== '0) begin
      n_fail++; $display("FAIL reset_mid_burst: got rd=%b v=%b id=%0d addr=%h len=%0d rr=%b", bus.rd_valid, bus.mem_req_valid, bus.mem_id, bus.mem_addr, bus.mem_len, bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; idle_all();
    model_last = NP - 1;
    set_req(3, 32'h3000, 1'b1, 2'd0, '0);
    bus.mem_req_ready = 1'b1;
    wait_issue(ok);
    n_tests++;
    if (!ok || bus.mem_id !== 2'd3) begin n_fail++; $display("FAIL post_reset_grant: got ok=%0d id=%0d want 3", ok, bus.mem_id); end
    model_last = 3;
    @(posedge clk); #1;
    idle_all();
    bus.mem_rd_valid = 1'b1;
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [NP-1:0] mask;
      logic [AW-1:0] a [NP];
      logic          r [NP];
      logic [1:0]    l [NP];
      logic [DW-1:0] w [NP];
      logic [NP-1:0] oh;
      logic [DW-1:0] d;
      int exp, dly, gap;
      bit ok;
      mask = 4'($urandom_range(1, 15));
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        a[p] = $urandom; r[p] = 1'($urandom_range(0, 1)); l[p] = 2'($urandom_range(0, 3)); w[p] = $urandom;
        if (mask[p]) set_req(p, a[p], r[p], l[p], w[p]);
      end
      exp = model_pick(mask);
      oh = 4'(1) << exp;
      wait_issue(ok);
      n_tests++;
      if (!ok || bus.mem_id !== 2'(exp) || bus.mem_addr !== a[exp] || bus.mem_rnw !== r[exp] ||
          (r[exp] && bus.mem_len !== l[exp]) || (!r[exp] && bus.mem_wdata !== w[exp])) begin
        n_fail++; $display("FAIL rand_issue%0d: got ok=%0d id=%0d addr=%h rnw=%b want id=%0d addr=%h rnw=%b", it, ok, bus.mem_id, bus.mem_addr, bus.mem_rnw, exp, a[exp], r[exp]);
      end
      dly = $urandom_range(0, 3);
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== '0 || bus.mem_req_valid !== 1'b1) begin
          n_fail++; $display("FAIL rand_wait%0d: got ready=%b v=%b want 0 1", it, bus.req_ready, bus.mem_req_valid);
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== oh) begin n_fail++; $display("FAIL rand_ready%0d: got %b want %b", it, bus.req_ready, oh); end
      model_last = exp;
      if (r[exp]) begin
        for (int b = 0; b <= int'(l[exp]); b++) begin
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            idle_all();
            @(negedge clk);
            n_tests++;
            if (bus.rd_valid !== '0) begin n_fail++; $display("FAIL rand_gap%0d: got rd_valid=%b want 0", it, bus.rd_valid); end
          end
          @(posedge clk); #1;
          idle_all();
          d = $urandom;
          bus.mem_rd_valid = 1'b1; bus.mem_rd_data = d;
          @(negedge clk);
          n_tests++;
          if (bus.rd_valid !== oh || bus.rd_data !== d) begin
            n_fail++; $display("FAIL rand_beat%0d_%0d: got rd_valid=%b data=%h want %b %h", it, b, bus.rd_valid, bus.rd_data, oh, d);
          end
        end
      end
      @(posedge clk); #1;
      idle_all();
      bus.mem_rd_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== '0 || bus.mem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand_done%0d: got rd_valid=%b v=%b want 0 0", it, bus.rd_valid, bus.mem_req_valid);
      end
      @(posedge clk); #1;
      idle_all();
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_stray_beat();
    test_write();
    test_round_robin();
    test_priority();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
